// File: rtl/trace_buffer_mem_if.sv
// Logger <-> trace memory port bundle.
// master = Logger side, slave = memory side.
interface trace_buffer_mem_if #(
  parameter int TRB_WIDTH      = 8,
  parameter int TRB_ADDR_WIDTH = 3
);
  logic                      RW_TURN_O;
  logic                      WRITE_I;
  logic [TRB_ADDR_WIDTH-1:0] WRITE_PTR_I;
  logic [TRB_WIDTH-1:0]      DMEM_I;
  logic [TRB_ADDR_WIDTH-1:0] READ_PTR_I;
  logic [TRB_WIDTH-1:0]      DMEM_O;
  logic                      WRITE_ALLOW_O;
  logic                      READ_ALLOW_O;
  logic [TRB_ADDR_WIDTH-1:0] FILL_O;
  logic                      OVERFLOW_O;

  modport master (
    input  RW_TURN_O, DMEM_O,
    input  WRITE_ALLOW_O, READ_ALLOW_O,
    input  FILL_O, OVERFLOW_O,
    output WRITE_I, WRITE_PTR_I,
    output DMEM_I, READ_PTR_I
  );

  modport slave (
    output RW_TURN_O, DMEM_O,
    output WRITE_ALLOW_O, READ_ALLOW_O,
    output FILL_O, OVERFLOW_O,
    input  WRITE_I, WRITE_PTR_I,
    input  DMEM_I, READ_PTR_I
  );
endinterface

// File: rtl/trace_buffer_mem.sv
// Circular trace memory with alternating write/read turns.
// Pointers belong to the Logger; only flags are derived here.
module trace_buffer_mem #(
  parameter int TRB_WIDTH      = 8,
  parameter int TRB_ADDR_WIDTH = 3
) (
  input  logic CLK_I,
  input  logic RST_NI,
  input  logic CLEAR_I,
  trace_buffer_mem_if.slave bus
);
  localparam int D = 2 ** TRB_ADDR_WIDTH;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } turn_e;

  turn_e turn_q, turn_d;

  logic [TRB_WIDTH-1:0]      mem [D];
  logic [TRB_WIDTH-1:0]      dout_q;
  logic                      wa_q, ra_q, ovf_q;
  logic [TRB_ADDR_WIDTH-1:0] fill_q;
  logic [TRB_ADDR_WIDTH-1:0] wp_nx;
  logic                      wr_req, wr_en, wr_rej;

  assign wp_nx  = bus.WRITE_PTR_I + TRB_ADDR_WIDTH'(1);
  assign wr_req = (turn_q == WR) & bus.WRITE_I & ~CLEAR_I;
  assign wr_en  = wr_req & wa_q;
  assign wr_rej = wr_req & ~wa_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) turn_q <= RD;
    else         turn_q <= turn_d;
  end

  always_comb begin
    turn_d = turn_q;
    if (CLEAR_I) begin
      turn_d = RD;
    end else begin
      unique case (turn_q)
        RD: turn_d = WR;
        WR: turn_d = RD;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      dout_q <= '0;
      wa_q   <= 1'b1;
      ra_q   <= 1'b0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else if (CLEAR_I) begin
      dout_q <= '0;
      wa_q   <= 1'b1;
      ra_q   <= 1'b0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (turn_q == RD) dout_q <= mem[bus.READ_PTR_I];
      // flags lag the pointers by one cycle by design
      wa_q   <= wp_nx != bus.READ_PTR_I;
      ra_q   <= bus.WRITE_PTR_I != bus.READ_PTR_I;
      fill_q <= bus.WRITE_PTR_I - bus.READ_PTR_I;
      if (wr_rej) ovf_q <= 1'b1;
    end
  end

  // storage is never reset so it can map onto block RAM
  always_ff @(posedge CLK_I) begin
    if (wr_en) mem[bus.WRITE_PTR_I] <= bus.DMEM_I;
  end

  assign bus.RW_TURN_O     = turn_q;
  assign bus.DMEM_O        = dout_q;
  assign bus.WRITE_ALLOW_O = wa_q;
  assign bus.READ_ALLOW_O  = ra_q;
  assign bus.FILL_O        = fill_q;
  assign bus.OVERFLOW_O    = ovf_q;
endmodule

// File: tb/tb_trace_buffer_mem.sv
// Bench for trace_buffer_mem: directed boundary steps plus
// random traffic against an arithmetic reference model.
module tb_trace_buffer_mem;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  trace_buffer_mem_if #(.TRB_WIDTH(8), .TRB_ADDR_WIDTH(3)) bus ();

  trace_buffer_mem #(.TRB_WIDTH(8), .TRB_ADDR_WIDTH(3)) dut (
    .CLK_I   (clk),
    .RST_NI  (rst_n),
    .CLEAR_I (clr),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mmem [8];
  bit         mval [8];
  bit         m_turn, m_wa, m_ra, m_ovf, m_dv;
  logic [7:0] m_dout;
  logic [2:0] m_fill;

  function automatic logic [7:0] pf(int i);
    return 8'(i * 17 + 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_turn = 0; m_dout = 8'h00; m_dv = 1;
    m_wa = 1; m_ra = 0; m_fill = 3'd0; m_ovf = 0;
  endtask

  task automatic check_model();
    chk("turn", 32'(bus.RW_TURN_O), 32'(m_turn));
    chk("wallow", 32'(bus.WRITE_ALLOW_O), 32'(m_wa));
    chk("rallow", 32'(bus.READ_ALLOW_O), 32'(m_ra));
    chk("fill", 32'(bus.FILL_O), 32'(m_fill));
    chk("ovf", 32'(bus.OVERFLOW_O), 32'(m_ovf));
    if (m_dv) chk("dout", 32'(bus.DMEM_O), 32'(m_dout));
  endtask

  task automatic step();
    int w, r;
    @(posedge clk);
    w = int'(bus.WRITE_PTR_I);
    r = int'(bus.READ_PTR_I);
    if (clr) begin
      model_reset();
    end else begin
      if (m_turn && bus.WRITE_I) begin
        if (m_wa) begin
          mmem[w] = bus.DMEM_I;
          mval[w] = 1;
        end else begin
          m_ovf = 1;
        end
      end
      if (!m_turn) begin
        m_dout = mmem[r];
        m_dv   = mval[r];
      end
      m_wa   = ((w + 1) % 8) != r;
      m_ra   = w != r;
      m_fill = 3'((w - r + 8) % 8);
      m_turn = !m_turn;
    end
    #1;
    check_model();
  endtask

  task automatic wr_word(int p, logic [7:0] d);
    bus.WRITE_PTR_I = 3'(p);
    bus.READ_PTR_I  = 3'((p + 4) % 8);
    bus.WRITE_I     = 1'b0;
    step();
    if (!m_turn) step();
    bus.WRITE_I = 1'b1;
    bus.DMEM_I  = d;
    step();
    bus.WRITE_I = 1'b0;
  endtask

  task automatic rd_word(int p, logic [7:0] exp, string tag);
    bus.WRITE_I     = 1'b0;
    bus.WRITE_PTR_I = 3'(p);
    bus.READ_PTR_I  = 3'(p);
    if (m_turn) step();
    step();
    chk(tag, 32'(bus.DMEM_O), 32'(exp));
  endtask

  initial begin
    bit e;
    for (int i = 0; i < 8; i++) mval[i] = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.WRITE_I     = 1'b0;
    bus.WRITE_PTR_I = 3'd0;
    bus.READ_PTR_I  = 3'd0;
    bus.DMEM_I      = 8'h00;
    model_reset();
    #12;
    check_model();
    rst_n = 1'b1;

    e = 0;
    for (int i = 0; i < 4; i++) begin
      chk("turn_seq", 32'(bus.RW_TURN_O), 32'(e));
      step();
      e = ~e;
    end

    for (int i = 0; i < 8; i++) wr_word(i, pf(i));

    wr_word(3, 8'hA5);
    bus.WRITE_PTR_I = 3'd4;
    bus.READ_PTR_I  = 3'd3;
    step();
    chk("rdback_a5", 32'(bus.DMEM_O), 32'hA5);
    step();
    chk("rdback_a5_hold", 32'(bus.DMEM_O), 32'hA5);

    bus.WRITE_PTR_I = 3'd7;
    bus.READ_PTR_I  = 3'd0;
    step();
    chk("full_wallow", 32'(bus.WRITE_ALLOW_O), 32'd0);
    chk("full_fill", 32'(bus.FILL_O), 32'd7);
    if (!m_turn) step();
    bus.WRITE_I = 1'b1;
    bus.DMEM_I  = 8'h5A;
    step();
    bus.WRITE_I = 1'b0;
    chk("ovf_set", 32'(bus.OVERFLOW_O), 32'd1);
    step();
    step();
    chk("ovf_sticky", 32'(bus.OVERFLOW_O), 32'd1);
    rd_word(7, pf(7), "full_mem_kept");

    bus.WRITE_PTR_I = 3'd1;
    bus.READ_PTR_I  = 3'd6;
    step();
    chk("wrap_fill", 32'(bus.FILL_O), 32'd3);
    chk("wrap_rallow", 32'(bus.READ_ALLOW_O), 32'd1);
    chk("wrap_wallow", 32'(bus.WRITE_ALLOW_O), 32'd1);
    bus.WRITE_PTR_I = 3'd5;
    bus.READ_PTR_I  = 3'd5;
    step();
    chk("empty_rallow", 32'(bus.READ_ALLOW_O), 32'd0);
    chk("empty_fill", 32'(bus.FILL_O), 32'd0);

    bus.WRITE_PTR_I = 3'd2;
    bus.READ_PTR_I  = 3'd6;
    bus.DMEM_I      = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      bus.WRITE_I = !m_turn;
      step();
    end
    bus.WRITE_I = 1'b0;
    rd_word(2, pf(2), "gate_mem_kept");

    bus.WRITE_PTR_I = 3'd4;
    bus.READ_PTR_I  = 3'd0;
    step();
    if (!m_turn) step();
    chk("ovf_pre_clear", 32'(bus.OVERFLOW_O), 32'd1);
    clr         = 1'b1;
    bus.WRITE_I = 1'b1;
    bus.DMEM_I  = 8'hEE;
    step();
    chk("clr_turn", 32'(bus.RW_TURN_O), 32'd0);
    chk("clr_ovf", 32'(bus.OVERFLOW_O), 32'd0);
    chk("clr_wallow", 32'(bus.WRITE_ALLOW_O), 32'd1);
    chk("clr_rallow", 32'(bus.READ_ALLOW_O), 32'd0);
    chk("clr_fill", 32'(bus.FILL_O), 32'd0);
    chk("clr_dout", 32'(bus.DMEM_O), 32'd0);
    clr         = 1'b0;
    bus.WRITE_I = 1'b0;
    step();
    chk("clr_next_turn", 32'(bus.RW_TURN_O), 32'd1);
    rd_word(4, pf(4), "clr_wr_suppressed");

    for (int i = 0; i < 400; i++) begin
      bus.WRITE_PTR_I = 3'($urandom_range(7));
      bus.READ_PTR_I  = 3'($urandom_range(7));
      bus.WRITE_I     = 1'($urandom_range(1));
      bus.DMEM_I      = 8'($urandom);
      clr             = ($urandom_range(31) == 0);
      step();
    end
    clr = 1'b0;

    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      chk("turn_seq_rerst", 32'(bus.RW_TURN_O), 32'(e));
      step();
      e = ~e;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_buffer_mem.md
# trace_buffer_mem

Dual-port circular trace memory that serves the Logger's memory interface in the streaming trace buffer. It generates the read/write turn strobe and the write/read permission flags, stores words at the Logger's write pointer, and returns words at the Logger's read pointer. It sits between the TraceLogger memory ports and the physical storage, in the Logger (`CLK_I`) domain.

## Interface
- `TRB_WIDTH`, default DTB_PKG `TRB_WIDTH`: data word width.
- `TRB_ADDR_WIDTH`, default DTB_PKG `TRB_ADDR_WIDTH`: pointer width; depth D = 2^TRB_ADDR_WIDTH; usable capacity D-1.
- `CLK_I`  in  1  single clock; one clock only.
- `RST_NI`  in  1  reset; asynchronous, active-low.
- `CLEAR_I`  in  1  synchronous flush of flags, output registers and turn phase; memory contents are untouched.
- `RW_TURN_O`  out  1  1 = write turn, 0 = read turn.
- `WRITE_I`  in  1  write intent from the Logger.
- `WRITE_PTR_I`  in  TRB_ADDR_WIDTH  write address.
- `DMEM_I`  in  TRB_WIDTH  write data.
- `READ_PTR_I`  in  TRB_ADDR_WIDTH  read address.
- `DMEM_O`  out  TRB_WIDTH  read data.
- `WRITE_ALLOW_O`  out  1  buffer not full.
- `READ_ALLOW_O`  out  1  buffer not empty.
- `FILL_O`  out  TRB_ADDR_WIDTH  occupancy: (WRITE_PTR_I − READ_PTR_I) mod D.
- `OVERFLOW_O`  out  1  sticky flag: write attempted while full.

## Operation
- Turn generator: a 1-bit register toggles every cycle, giving W, R, W, R, and so on.
- Write commit: occurs in a cycle where RW_TURN_O=1, WRITE_I=1 and WRITE_ALLOW_O=1.
  - Effect: mem[WRITE_PTR_I] <= DMEM_I at that clock edge.
  - In any other cycle, the memory is not written.
- Rejected write: RW_TURN_O=1, WRITE_I=1 and WRITE_ALLOW_O=0.
  - No memory write.
  - OVERFLOW_O is set and holds until reset or CLEAR_I.
- Read: in every cycle with RW_TURN_O=0, DMEM_O <= mem[READ_PTR_I]. DMEM_O holds its value during write turns.
- Flags are registered from the current pointers every cycle:
  - WRITE_ALLOW_O <= ((WRITE_PTR_I+1) mod D) != READ_PTR_I
  - READ_ALLOW_O <= WRITE_PTR_I != READ_PTR_I
  - FILL_O <= WRITE_PTR_I − READ_PTR_I, unsigned, wraps modulo D.
- The block keeps no pointer state of its own. The pointers are owned by the Logger, which advances them only after using the flags.
- Read/write collision cannot occur, because the turns are exclusive. No bypass path exists.
- CLEAR_I (synchronous, highest priority after reset):
  - RW_TURN_O <= 0, DMEM_O <= 0, OVERFLOW_O <= 0
  - WRITE_ALLOW_O <= 1, READ_ALLOW_O <= 0, FILL_O <= 0
  - Any write in the same cycle is suppressed.
- Storage: a plain register array or inferred simple-dual-port RAM with synchronous read. Memory contents are not reset.

## Timing
- Reset values of outputs:
  - RW_TURN_O=0, DMEM_O=0, WRITE_ALLOW_O=1, READ_ALLOW_O=0, FILL_O=0, OVERFLOW_O=0.
- First cycle after reset release is a read turn. The second is a write turn.
- Write latency: data is in memory at the write-turn edge and is readable at the next read turn.
- Read latency: DMEM_O is valid one cycle after the read-turn edge.
  - It stays stable across the following write turn: two cycles of validity.
- Flag latency: exactly one cycle after a pointer change.
  - Because of this lag, the Logger must sample WRITE_ALLOW_O and READ_ALLOW_O only on the turn following a pointer update.
  - Alternating turns guarantee that gap.
- Wrap-around boundaries:
  - Pointers D−1 → 0 need no special handling, since arithmetic is modulo D.
  - Full is defined as WRITE_PTR_I = READ_PTR_I − 1 mod D.
  - Empty is defined as equal pointers.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronous). The turn restarts at read on release.

## Test plan
- Reset: assert RST_NI low mid-cycle -> all outputs at their reset values without a clock edge. After release, RW_TURN_O sequence is 0,1,0,1.
- Write/read-back (D=8, W=8): write 0xA5 at ptr 3 on a write turn, then READ_PTR_I=3 -> DMEM_O=0xA5 one cycle after the next read turn, held two cycles.
- Full boundary: WRITE_PTR_I=7, READ_PTR_I=0 -> next cycle WRITE_ALLOW_O=0, FILL_O=7. WRITE_I on a write turn -> memory unchanged, OVERFLOW_O=1 and sticky.
- Wrap: WRITE_PTR_I=1, READ_PTR_I=6 -> FILL_O=3, READ_ALLOW_O=1, WRITE_ALLOW_O=1. Equal pointers 5/5 -> READ_ALLOW_O=0, FILL_O=0.
- Write-turn gating: WRITE_I=1 held only on read turns with pattern 0x3C -> no memory change, verified by read-back of the old value.
- CLEAR_I with OVERFLOW_O=1 and a concurrent write -> flags reset as specified, write suppressed, next cycle RW_TURN_O=1.
